// File: rtl/hidden_cpu_sequencer.sv
// Buffers a short program of instruction words and replays it for a programmed number of passes.
// Optional HIDDENCPU_SEQ_STEP_EN adds a step_i input that gates each issued word.
module hidden_cpu_sequencer #(
    parameter int DEPTH = 16,
    parameter int IW    = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_i,
    input  logic                     load_valid_i,
    input  logic [IW-1:0]            load_data_i,
    output logic                     load_ready_o,
    input  logic                     start_i,
    input  logic [7:0]               loop_count_i,
    input  logic                     halt_i,
`ifdef HIDDENCPU_SEQ_STEP_EN
    input  logic                     step_i,
`endif
    output logic [IW-1:0]            instr_out_o,
    output logic                     instr_valid_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [$clog2(DEPTH):0]   prog_len_o
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e          state_q;
    logic [AW:0]     prog_len_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [7:0]      pass_cnt_q;
    logic [7:0]      loop_q;
    logic [IW-1:0]   out_q;
    logic            valid_q;
    logic            busy_q;
    logic            done_q;
    logic [IW-1:0]   mem_q [DEPTH];

    logic            load_fire;
    logic            issue_en;
    logic            last_word;
    logic            last_pass;
    logic [AW-1:0]   rd_ptr_d;
    logic [AW:0]     prog_len_d;

`ifdef HIDDENCPU_SEQ_STEP_EN
    assign issue_en = step_i;
`else
    assign issue_en = 1'b1;
`endif

    assign load_ready_o = (state_q == IDLE) && (prog_len_q < (AW+1)'(DEPTH)) && !clear_i;
    assign load_fire    = load_valid_i && load_ready_o;
    assign prog_len_d   = load_fire ? prog_len_q + (AW+1)'(1) : prog_len_q;

    // out_q always holds buf[rd_ptr_q]; a word is consumed on each edge where it is issued.
    assign last_word = ({1'b0, rd_ptr_q} == prog_len_q - (AW+1)'(1));
    assign last_pass = (loop_q != 8'd0) && (pass_cnt_q + 8'd1 == loop_q);
    assign rd_ptr_d  = last_word ? '0 : rd_ptr_q + AW'(1);

    // NOTE: the program buffer is plain storage with no reset; prog_len_q alone marks valid entries.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            mem_q[prog_len_q[AW-1:0]] <= load_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            prog_len_q <= '0;
            rd_ptr_q   <= '0;
            pass_cnt_q <= '0;
            loop_q     <= '0;
            out_q      <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (clear_i) begin
                        prog_len_q <= '0;
                    end else begin
                        prog_len_q <= prog_len_d;
                        // A word loaded alongside start lands behind buf[0], so it joins this run.
                        if (start_i && prog_len_q != '0) begin
                            state_q    <= RUN;
                            rd_ptr_q   <= '0;
                            pass_cnt_q <= '0;
                            loop_q     <= loop_count_i;
                            out_q      <= mem_q[0];
                            valid_q    <= 1'b1;
                            busy_q     <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (halt_i) begin
                        state_q <= IDLE;
                        out_q   <= '0;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (issue_en) begin
                        if (last_word && last_pass) begin
                            state_q <= DONE;
                            out_q   <= '0;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            rd_ptr_q <= rd_ptr_d;
                            out_q    <= mem_q[rd_ptr_d];
                            if (last_word) begin
                                pass_cnt_q <= pass_cnt_q + 8'd1;
                            end
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign instr_valid_o = valid_q && issue_en;
    assign instr_out_o   = issue_en ? out_q : '0;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign prog_len_o    = prog_len_q;

endmodule

// File: tb/tb_hidden_cpu_sequencer.sv
// Scoreboard bench for hidden_cpu_sequencer: a queue-based program model feeds expected words to a negedge monitor.
module tb_hidden_cpu_sequencer;

    localparam int DEPTH = 16;
    localparam int IW    = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear, load_valid, start, halt, step;
    logic [IW-1:0] load_data;
    logic [7:0]    loop_count;
    logic          load_ready, instr_valid, busy, done;
    logic [IW-1:0] instr_out;
    logic [4:0]    prog_len;

    typedef struct {
        logic          is_done;
        logic [IW-1:0] word;
    } exp_t;

    exp_t          exp_q[$];
    logic [IW-1:0] model_buf[$];
    int            check_cnt = 0;
    int            err_cnt   = 0;

    hidden_cpu_sequencer #(.DEPTH(DEPTH), .IW(IW)) dut (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (clear),
        .load_valid_i (load_valid),
        .load_data_i  (load_data),
        .load_ready_o (load_ready),
        .start_i      (start),
        .loop_count_i (loop_count),
        .halt_i       (halt),
`ifdef HIDDENCPU_SEQ_STEP_EN
        .step_i       (step),
`endif
        .instr_out_o  (instr_out),
        .instr_valid_o(instr_valid),
        .busy_o       (busy),
        .done_o       (done),
        .prog_len_o   (prog_len)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every falling edge the DUT must show exactly what the scoreboard head predicts.
    always @(negedge clk) begin
        if (!rst) begin
            logic stalled;
`ifdef HIDDENCPU_SEQ_STEP_EN
            stalled = !step;
`else
            stalled = 1'b0;
`endif
            if (exp_q.size() == 0) begin
                check("idle_valid", instr_valid, 0);
                check("idle_done", done, 0);
            end else if (exp_q[0].is_done) begin
                check("done_pulse", done, 1);
                check("done_valid", instr_valid, 0);
                void'(exp_q.pop_front());
            end else if (stalled) begin
                check("stall_valid", instr_valid, 0);
            end else begin
                check("word_valid", instr_valid, 1);
                check("word_data", instr_out, exp_q[0].word);
                void'(exp_q.pop_front());
            end
        end
    end

    // Expected replay: halt_after > 0 cuts the stream after that many words and suppresses done.
    task automatic push_expected(input int loop, input int halt_after);
        int n;
        int total;
        total = loop * model_buf.size();
        n = (halt_after > 0) ? halt_after : total;
        for (int k = 0; k < n; k++) begin
            exp_q.push_back('{is_done: 1'b0, word: model_buf[k % model_buf.size()]});
        end
        if (halt_after == 0) exp_q.push_back('{is_done: 1'b1, word: '0});
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            if (!busy) break;
            @(posedge clk); #1;
        end
        check("idle_timeout", busy, 0);
        @(posedge clk); #1;
        check("sb_drained", exp_q.size(), 0);
    endtask

    task automatic load_word(input logic [IW-1:0] w);
        load_valid = 1'b1;
        load_data  = w;
        #1 check("load_ready", load_ready, model_buf.size() < DEPTH);
        @(posedge clk);
        if (model_buf.size() < DEPTH) model_buf.push_back(w);
        #1 load_valid = 1'b0;
    endtask

    task automatic clear_buf();
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        model_buf.delete();
    endtask

    task automatic run_prog(input int loop, input int halt_after, input bit with_load, input logic [IW-1:0] w);
        start      = 1'b1;
        loop_count = 8'(loop);
        if (with_load) begin
            load_valid = 1'b1;
            load_data  = w;
        end
        @(posedge clk);
        if (with_load && model_buf.size() < DEPTH) model_buf.push_back(w);
        push_expected(loop, halt_after);
        #1 start = 1'b0;
        load_valid = 1'b0;
        if (halt_after > 0) begin
            repeat (halt_after - 1) @(posedge clk);
            #1 halt = 1'b1;
            @(posedge clk);
            #1 halt = 1'b0;
        end
        wait_idle();
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; load_valid = 1'b0; load_data = '0;
        start = 1'b0; halt = 1'b0; step = 1'b1; loop_count = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_prog_len", prog_len, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_out", instr_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_load_ready", load_ready, 1);

        // Three-word program, two passes.
        load_word(6'h11); load_word(6'h22); load_word(6'h33);
        check("len3", prog_len, 3);
        run_prog(2, 0, 1'b0, '0);

        // clear and start together: buffer empties, no run.
        clear = 1'b1; start = 1'b1; loop_count = 8'd1;
        #1 check("clear_blocks_ready", load_ready, 0);
        @(posedge clk);
        #1 clear = 1'b0; start = 1'b0;
        model_buf.delete();
        check("clear_len", prog_len, 0);
        check("clear_no_run", busy, 0);

        // start on an empty buffer is ignored.
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("empty_start_busy", busy, 0);
        @(posedge clk); #1;
        check("empty_start_busy2", busy, 0);

        // Offer 17 words: the 17th is refused and never replayed.
        for (int i = 0; i < 17; i++) load_word(IW'($urandom));
        check("full_len", prog_len, DEPTH);
        check("full_ready", load_ready, 0);
        run_prog(1, 0, 1'b0, '0);

        // Endless loop halted on the 10th issued word.
        clear_buf();
        for (int i = 0; i < 4; i++) load_word(IW'(i + 1));
        run_prog(0, 10, 1'b0, '0);

        // Randomised programs, loop counts, halts and load-with-start.
        for (int it = 0; it < 8; it++) begin
            int  len, loop, halt_after;
            bit  with_load;
            clear_buf();
            len = $urandom_range(1, DEPTH - 1);
            for (int i = 0; i < len; i++) load_word(IW'($urandom));
            check("rand_len", prog_len, model_buf.size());
            with_load = 1'($urandom_range(0, 1));
            loop = $urandom_range(0, 3);
            if (loop == 0) halt_after = $urandom_range(1, 40);
            else if ($urandom_range(0, 2) == 0) halt_after = $urandom_range(1, loop * (len + int'(with_load)));
            else halt_after = 0;
            run_prog(loop, halt_after, with_load, IW'($urandom));
        end

        // Asynchronous reset in the middle of an endless run.
        clear_buf();
        for (int i = 0; i < 4; i++) load_word(IW'($urandom));
        start = 1'b1; loop_count = 8'd0;
        @(posedge clk);
        for (int k = 0; k < 40; k++) exp_q.push_back('{is_done: 1'b0, word: model_buf[k % 4]});
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        exp_q.delete();
        #1;
        check("async_rst_valid", instr_valid, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_len", prog_len, 0);
        #3 rst = 1'b0;
        model_buf.delete();
        @(posedge clk); #1;

`ifdef HIDDENCPU_SEQ_STEP_EN
        // Two words, one pass, step pulsed every third cycle.
        load_word(6'h2a); load_word(6'h15);
        step = 1'b0; start = 1'b1; loop_count = 8'd1;
        @(posedge clk);
        push_expected(1, 0);
        #1 start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step = (i % 3 == 2);
            @(posedge clk); #1;
        end
        step = 1'b1;
        wait_idle();
`endif

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
        $finish;
    end

endmodule
